// File: rtl/zpu_mem_arbiter.sv
// Two-port round-robin arbiter in front of the single-cycle internal RAM.
// One transaction at a time: IDLE (arbitrate) -> ACCESS (RAM cycle) -> DONE (done pulse).
module zpu_mem_arbiter #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   output logic                  m0_done,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  m1_done,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_write_en,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   output logic [1:0]            grant
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_DONE   = 2'b10
   } state_t;

   state_t                  state_r;
   state_t                  state_next_s;
   logic                    last_owner_r;
   logic [1:0]              grant_r;
   logic [1:0]              done_r;
   logic [ADDR_WIDTH-1:0]   ram_addr_r;
   logic [DATA_WIDTH-1:0]   ram_din_r;
   logic                    ram_write_en_r;
   logic                    req0_s;
   logic                    req1_s;
   logic                    winner_s;
   logic                    take_s;

   // Request decode and round-robin winner selection
   always_comb begin
      req0_s   = m0_read | m0_write;
      req1_s   = m1_read | m1_write;
      take_s   = (state_r == ST_IDLE) && (req0_s || req1_s);
      winner_s = 1'b0;
      if (req0_s && req1_s) begin
         winner_s = ~last_owner_r;
      end else if (req1_s) begin
         winner_s = 1'b1;
      end else begin
         winner_s = 1'b0;
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (take_s) state_next_s = ST_ACCESS;
            else        state_next_s = ST_IDLE;
         end
         ST_ACCESS: state_next_s = ST_DONE;
         ST_DONE:   state_next_s = ST_IDLE;
         default:   state_next_s = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_r <= ST_IDLE;
      else       state_r <= state_next_s;
   end

   // RAM request registers, owner tracking and done pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         last_owner_r   <= 1'b1;
         grant_r        <= 2'b00;
         done_r         <= 2'b00;
         ram_addr_r     <= '0;
         ram_din_r      <= '0;
         ram_write_en_r <= 1'b0;
      end else begin
         done_r         <= 2'b00;
         ram_write_en_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (take_s) begin
                  last_owner_r   <= winner_s;
                  grant_r        <= winner_s ? 2'b10 : 2'b01;
                  ram_addr_r     <= winner_s ? m1_addr  : m0_addr;
                  ram_din_r      <= winner_s ? m1_wdata : m0_wdata;
                  // read+write together on one port counts as a write
                  ram_write_en_r <= winner_s ? m1_write : m0_write;
               end
            end
            ST_ACCESS: done_r  <= grant_r;
            ST_DONE:   grant_r <= 2'b00;
            default:   grant_r <= 2'b00;
         endcase
      end
   end

   assign ram_addr     = ram_addr_r;
   assign ram_din      = ram_din_r;
   assign ram_write_en = ram_write_en_r;
   assign grant        = grant_r;
   assign m0_done      = done_r[0];
   assign m1_done      = done_r[1];
   // RAM output is broadcast; each port qualifies it with its own done
   assign m0_rdata     = ram_dout;
   assign m1_rdata     = ram_dout;

endmodule

// File: doc/zpu_mem_arbiter.md
Name: zpu_mem_arbiter

Overview:
- Two-port arbiter sharing the single-cycle internal RAM between the ZPU core (port 0) and a second bus master (port 1, e.g. a serial program loader or debug DMA).
- Each port presents the ZPU memory handshake: read/write strobes held until a done pulse.
- Sits between the masters and the RAM in the top level and replaces the fixed `mem_done = 1` tie-off with a real per-port done.
- Round-robin fairness; one transaction in flight at a time.

Parameters:
- ADDR_WIDTH, 10, word address width of RAM and both ports
- DATA_WIDTH, 32, data width of RAM and both ports

Ports:
- clk  input  1  system clock, single clock domain
- reset  input  1  synchronous, active-high reset
- m0_read  input  1  port 0 (CPU) read request, level, held until m0_done
- m0_write  input  1  port 0 write request, level, held until m0_done
- m0_addr  input  ADDR_WIDTH  port 0 address
- m0_wdata  input  DATA_WIDTH  port 0 write data
- m0_rdata  output  DATA_WIDTH  port 0 read data, valid only while m0_done=1
- m0_done  output  1  port 0 completion pulse, one cycle
- m1_read, m1_write, m1_addr, m1_wdata, m1_rdata, m1_done  same as port 0, for port 1
- ram_addr  output  ADDR_WIDTH  RAM address, registered
- ram_write_en  output  1  RAM write enable, registered
- ram_din  output  DATA_WIDTH  RAM write data, registered
- ram_dout  input  DATA_WIDTH  RAM read data, valid one cycle after address presented
- grant  output  2  one-hot current owner; 00 when idle

Behaviour:
- Reset (sync, active-high):
  - state=IDLE; ram_write_en=0; ram_addr=0; ram_din=0.
  - grant=00; m0_done=m1_done=0.
  - last_owner=1, so port 0 wins the first tie.
- States: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - A port requests when read|write is high.
  - If no port requests, stay in IDLE.
  - If one port requests, it wins.
  - If both request, the port != last_owner wins.
  - At the clock edge: owner and last_owner <= winner; ram_addr <= winner addr; ram_din <= winner wdata; ram_write_en <= winner write; state <= ACCESS.
- ACCESS (cycle N+1):
  - RAM samples ram_addr/ram_write_en/ram_din at the closing edge.
  - At that edge: ram_write_en <= 0; state <= DONE.
- DONE (cycle N+2):
  - m<owner>_done=1 for exactly this cycle.
  - m<owner>_rdata = ram_dout. Both rdata outputs may be broadcast from ram_dout, but are only meaningful while done=1.
  - At the closing edge: state <= IDLE; grant <= 00.
- Latency and throughput:
  - Request sampled in cycle N; done in cycle N+2.
  - Minimum 3 cycles per transaction; no pipelining.
- grant is one-hot to the owner in ACCESS and DONE; 00 in IDLE.
- Handshake rules:
  - A master holds read/write, addr and wdata stable until it sees done.
  - A master drops its request in the cycle after done, or issues a new one.
  - A request still high in the IDLE cycle after DONE is treated as a new transaction.
  - The arbiter samples addr/wdata only in IDLE, so later changes do not affect the in-flight access.
- read=1 and write=1 together on one port is illegal and is treated as a write; rdata is then don't-care.
- A losing requester keeps waiting with its request held. Round-robin guarantees it wins the next arbitration, so worst-case wait is one foreign transaction (3 cycles) plus its own 3.
- Requests arriving during ACCESS/DONE are ignored until IDLE.
- Reset mid-operation:
  - If reset is high in ACCESS, the RAM write already presented still commits at that edge. Outputs are cleared at the same edge and no done is issued.
  - If reset is high in DONE, done is still visible combinationally in that cycle; masters must also honour reset themselves.
  - last_owner returns to 1.
- No address decoding; full ADDR_WIDTH is passed through. Widths never change; no arithmetic.

Test Plan:
- Reset: hold reset 2 cycles with both ports requesting -> ram_write_en=0, grant=00, no done. After release, the first grant goes to port 0 (grant=01).
- Single read: m0_read, m0_addr=0x005 with RAM word 5=0xDEADBEEF preloaded -> ram_addr=0x005 in cycle N+1; m0_done=1 and m0_rdata=0xDEADBEEF in cycle N+2; m1_done stays 0.
- Write then read: m1_write addr=0x3FF wdata=0x12345678 -> ram_write_en high exactly one cycle (N+1), m1_done at N+2. A following m1_read of 0x3FF returns 0x12345678.
- Contention: both ports hold continuous reads (m0 addr 0x010, m1 addr 0x020) for 12 cycles -> grants alternate 01,10,01,10; each port gets a done every 6 cycles; no port is starved.
- Illegal strobe: m0_read=m0_write=1, addr 0x007, wdata 0xA5A5A5A5 -> treated as a write; RAM word 7 becomes 0xA5A5A5A5; m0_done at N+2.
- Reset mid-write: assert reset during ACCESS of m0_write addr 0x001 wdata 0x55 -> word 1 = 0x55, m0_done never pulses, state IDLE next cycle, grant=00.
